// File: rtl/bus_sequencer_if.sv
// Control bundle between the bus sequencer and the shared 25-source datapath bus.
interface bus_sequencer_if;
  // Inputs to the sequencer
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  // Bus source enables
  logic [15:0] r_out;
  logic        hi_out;
  logic        lo_out;
  logic        zhi_out;
  logic        zlo_out;
  logic        pc_out;
  logic        mdr_out;
  logic        csign_out;
  // Load / control strobes
  logic [15:0] r_in;
  logic        pc_in;
  logic        ir_in;
  logic        mar_in;
  logic        mdr_in;
  logic        y_in;
  logic        z_in;
  logic        hi_in;
  logic        lo_in;
  logic        inc_pc;
  logic        read;
  logic [4:0]  alu_op;
  // Status
  logic        busy;
  logic        done;
  logic        halted;
  logic        illegal;

  modport master (
    input  run, ir, mem_ready,
    output r_out, hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, csign_out,
    output r_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, read,
    output alu_op, busy, done, halted, illegal
  );

  modport slave (
    output run, ir, mem_ready,
    input  r_out, hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, csign_out,
    input  r_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, read,
    input  alu_op, busy, done, halted, illegal
  );
endinterface

// File: rtl/bus_sequencer.sv
// Control-step sequencer: fetch (T0-T2) and execute (T3-T6) for the shared datapath bus.
// Every step drives at most one bus source; the bus itself resolves overlaps silently.
module bus_sequencer #(
  parameter int unsigned OPW  = 5,
  parameter int unsigned REGW = 4
) (
  input  logic            clock,
  input  logic            clear,
  bus_sequencer_if.master bus
);

  localparam int unsigned NREG   = 16;
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned RA_MSB = OP_MSB - OPW;
  localparam int unsigned RB_MSB = RA_MSB - REGW;
  localparam int unsigned RC_MSB = RB_MSB - REGW;
  localparam int unsigned RC_LSB = RC_MSB - REGW + 1;

  localparam logic [OPW-1:0] OP_ALU_LO = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_ALU_HI = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_IMM_LO = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_IMM_HI = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_DIV    = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_MUL    = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_NEG    = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_NOT    = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_MFHI   = OPW'(5'b11001);
  localparam logic [OPW-1:0] OP_MFLO   = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_NOP    = OPW'(5'b11011);
  localparam logic [OPW-1:0] OP_HALT   = OPW'(5'b11100);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALT, FAULT
  } seqState;

  seqState state;
  seqState nextState;
  logic    pcLoaded;

  logic [OPW-1:0]  opcode;
  logic [REGW-1:0] ra;
  logic [REGW-1:0] rb;
  logic [REGW-1:0] rc;
  logic            isRegAlu;
  logic            isImm;
  logic            isMulDiv;
  logic            isUnary;
  logic            unusedIr;

  function automatic logic [NREG-1:0] regSelect(input logic [REGW-1:0] idx);
    return NREG'(1) << idx;
  endfunction

  // Instruction field extraction and opcode class decode
  assign opcode   = bus.ir[OP_MSB -: OPW];
  assign ra       = bus.ir[RA_MSB -: REGW];
  assign rb       = bus.ir[RB_MSB -: REGW];
  assign rc       = bus.ir[RC_MSB -: REGW];
  assign unusedIr = ^bus.ir[RC_LSB-1:0];
  assign isRegAlu = (opcode >= OP_ALU_LO) && (opcode <= OP_ALU_HI);
  assign isImm    = (opcode >= OP_IMM_LO) && (opcode <= OP_IMM_HI);
  assign isMulDiv = (opcode == OP_DIV) || (opcode == OP_MUL);
  assign isUnary  = (opcode == OP_NEG) || (opcode == OP_NOT);

  // State register; pcLoaded remembers that the current T1 already pulsed pc_in
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      pcLoaded <= 1'b0;
    end else begin
      state    <= nextState;
      pcLoaded <= (state == T1);
    end
  end

  // Next-state and Moore output decode from the registered state and ir
  always_comb begin
    nextState     = state;
    bus.r_out     = '0;
    bus.hi_out    = 1'b0;
    bus.lo_out    = 1'b0;
    bus.zhi_out   = 1'b0;
    bus.zlo_out   = 1'b0;
    bus.pc_out    = 1'b0;
    bus.mdr_out   = 1'b0;
    bus.csign_out = 1'b0;
    bus.r_in      = '0;
    bus.pc_in     = 1'b0;
    bus.ir_in     = 1'b0;
    bus.mar_in    = 1'b0;
    bus.mdr_in    = 1'b0;
    bus.y_in      = 1'b0;
    bus.z_in      = 1'b0;
    bus.hi_in     = 1'b0;
    bus.lo_in     = 1'b0;
    bus.inc_pc    = 1'b0;
    bus.read      = 1'b0;
    bus.alu_op    = '0;
    bus.done      = 1'b0;
    bus.halted    = 1'b0;
    bus.illegal   = 1'b0;
    bus.busy      = !(state inside {IDLE, HALT, FAULT});

    case (state)
      IDLE: begin
        if (bus.run) nextState = T0;
      end
      T0: begin
        bus.pc_out = 1'b1;
        bus.mar_in = 1'b1;
        bus.inc_pc = 1'b1;
        bus.z_in   = 1'b1;
        nextState  = T1;
      end
      T1: begin
        bus.zlo_out = 1'b1;
        bus.pc_in   = !pcLoaded;
        bus.read    = 1'b1;
        bus.mdr_in  = 1'b1;
        if (bus.mem_ready) nextState = T2;
      end
      T2: begin
        bus.mdr_out = 1'b1;
        bus.ir_in   = 1'b1;
        if (opcode == OP_NOP) begin
          bus.done  = 1'b1;
          nextState = bus.run ? T0 : IDLE;
        end else begin
          nextState = T3;
        end
      end
      T3: begin
        if (isRegAlu || isImm) begin
          bus.r_out = regSelect(rb);
          bus.y_in  = 1'b1;
          nextState = T4;
        end else if (isUnary) begin
          bus.r_out  = regSelect(rb);
          bus.alu_op = 5'(opcode);
          bus.z_in   = 1'b1;
          nextState  = T4;
        end else if (isMulDiv) begin
          bus.r_out = regSelect(ra);
          bus.y_in  = 1'b1;
          nextState = T4;
        end else if (opcode == OP_MFHI || opcode == OP_MFLO) begin
          bus.hi_out = (opcode == OP_MFHI);
          bus.lo_out = (opcode == OP_MFLO);
          bus.r_in   = regSelect(ra);
          bus.done   = 1'b1;
          nextState  = bus.run ? T0 : IDLE;
        end else if (opcode == OP_HALT) begin
          nextState = HALT;
        end else begin
          nextState = FAULT;
        end
      end
      T4: begin
        if (isRegAlu || isImm) begin
          bus.r_out     = isImm ? '0 : regSelect(rc);
          bus.csign_out = isImm;
          bus.alu_op    = 5'(opcode);
          bus.z_in      = 1'b1;
          nextState     = T5;
        end else if (isUnary) begin
          bus.zlo_out = 1'b1;
          bus.r_in    = regSelect(ra);
          bus.done    = 1'b1;
          nextState   = bus.run ? T0 : IDLE;
        end else if (isMulDiv) begin
          bus.r_out  = regSelect(rb);
          bus.alu_op = 5'(opcode);
          bus.z_in   = 1'b1;
          nextState  = T5;
        end else begin
          nextState = FAULT;
        end
      end
      T5: begin
        if (isRegAlu || isImm) begin
          bus.zlo_out = 1'b1;
          bus.r_in    = regSelect(ra);
          bus.done    = 1'b1;
          nextState   = bus.run ? T0 : IDLE;
        end else if (isMulDiv) begin
          bus.zlo_out = 1'b1;
          bus.lo_in   = 1'b1;
          nextState   = T6;
        end else begin
          nextState = FAULT;
        end
      end
      T6: begin
        if (isMulDiv) begin
          bus.zhi_out = 1'b1;
          bus.hi_in   = 1'b1;
          bus.done    = 1'b1;
          nextState   = bus.run ? T0 : IDLE;
        end else begin
          nextState = FAULT;
        end
      end
      HALT: begin
        bus.halted = 1'b1;
      end
      FAULT: begin
        bus.illegal = 1'b1;
      end
      default: begin
        nextState = FAULT;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: per-cycle strobe tables for each instruction class.
module tb_bus_sequencer;

  // Strobe snapshot bit positions
  localparam logic [20:0] HI_OUT    = 21'(1) << 20;
  localparam logic [20:0] LO_OUT    = 21'(1) << 19;
  localparam logic [20:0] ZHI_OUT   = 21'(1) << 18;
  localparam logic [20:0] ZLO_OUT   = 21'(1) << 17;
  localparam logic [20:0] PC_OUT    = 21'(1) << 16;
  localparam logic [20:0] MDR_OUT   = 21'(1) << 15;
  localparam logic [20:0] CSIGN_OUT = 21'(1) << 14;
  localparam logic [20:0] PC_IN     = 21'(1) << 13;
  localparam logic [20:0] IR_IN     = 21'(1) << 12;
  localparam logic [20:0] MAR_IN    = 21'(1) << 11;
  localparam logic [20:0] MDR_IN    = 21'(1) << 10;
  localparam logic [20:0] Y_IN      = 21'(1) << 9;
  localparam logic [20:0] Z_IN      = 21'(1) << 8;
  localparam logic [20:0] HI_IN     = 21'(1) << 7;
  localparam logic [20:0] LO_IN     = 21'(1) << 6;
  localparam logic [20:0] INC_PC    = 21'(1) << 5;
  localparam logic [20:0] READ      = 21'(1) << 4;
  localparam logic [20:0] BUSY      = 21'(1) << 3;
  localparam logic [20:0] DONE      = 21'(1) << 2;
  localparam logic [20:0] HALTED    = 21'(1) << 1;
  localparam logic [20:0] ILLEGAL   = 21'(1) << 0;

  localparam logic [20:0] FETCH0 = PC_OUT | MAR_IN | INC_PC | Z_IN | BUSY;
  localparam logic [20:0] FETCH1 = ZLO_OUT | PC_IN | READ | MDR_IN | BUSY;
  localparam logic [20:0] FETCH1W = ZLO_OUT | READ | MDR_IN | BUSY;
  localparam logic [20:0] FETCH2 = MDR_OUT | IR_IN | BUSY;

  logic clock;
  logic clear;
  int   checks;
  int   failures;
  int   busViolations;
  int   rinViolations;
  logic [20:0] strobes;

  bus_sequencer_if bus ();

  bus_sequencer #(.OPW(5), .REGW(4)) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign strobes = {bus.hi_out, bus.lo_out, bus.zhi_out, bus.zlo_out, bus.pc_out,
                    bus.mdr_out, bus.csign_out, bus.pc_in, bus.ir_in, bus.mar_in,
                    bus.mdr_in, bus.y_in, bus.z_in, bus.hi_in, bus.lo_in, bus.inc_pc,
                    bus.read, bus.busy, bus.done, bus.halted, bus.illegal};

  // Bus-contention and r_in one-hot monitor, sampled mid-cycle
  always @(negedge clock) begin
    int srcCount;
    srcCount = $countones(bus.r_out) + $countones(bus.hi_out) + $countones(bus.lo_out)
             + $countones(bus.zhi_out) + $countones(bus.zlo_out) + $countones(bus.pc_out)
             + $countones(bus.mdr_out) + $countones(bus.csign_out);
    if (srcCount > 1) begin
      busViolations++;
      $display("FAIL bus_contention t=%0t sources=%0d (allowed at most 1)", $time, srcCount);
    end
    if ($countones(bus.r_in) > 1) rinViolations++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear         = 1'b1;
    bus.run       = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    bus.ir = 32'h1891_8000;
    do_reset();
    checks++;
    if (strobes !== 21'd0 || bus.r_out !== 16'd0 || bus.r_in !== 16'd0 || bus.alu_op !== 5'd0) begin
      failures++;
      $display("FAIL reset_idle: strobes=%h r_out=%h r_in=%h alu_op=%h, required all 0",
               strobes, bus.r_out, bus.r_in, bus.alu_op);
    end
    tick();
    checks++;
    if (strobes !== 21'd0) begin
      failures++;
      $display("FAIL idle_hold_run0: strobes=%h, required 0", strobes);
    end
  endtask

  task automatic test_add();
    logic [20:0] es [7];
    logic [15:0] er [7];
    logic [15:0] ei [7];
    logic [4:0]  eo [7];
    es = '{FETCH0, FETCH1, FETCH2, Y_IN | BUSY, Z_IN | BUSY, ZLO_OUT | DONE | BUSY, FETCH0};
    er = '{16'h0, 16'h0, 16'h0, 16'h0004, 16'h0008, 16'h0, 16'h0};
    ei = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0002, 16'h0};
    eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0};
    bus.ir = 32'h1891_8000;
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (strobes !== es[i] || bus.r_out !== er[i] || bus.r_in !== ei[i] || bus.alu_op !== eo[i]) begin
        failures++;
        $display("FAIL add cyc%0d: strobes=%h r_out=%h r_in=%h alu_op=%h, required %h %h %h %h",
                 i, strobes, bus.r_out, bus.r_in, bus.alu_op, es[i], er[i], ei[i], eo[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [20:0] es [6];
    logic        mr [6];
    int          pcInCount;
    es = '{FETCH0, FETCH1, FETCH1W, FETCH1W, FETCH1W, FETCH2};
    mr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    pcInCount = 0;
    bus.ir = 32'h1891_8000;
    do_reset();
    bus.mem_ready = 1'b0;
    bus.run       = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.mem_ready = mr[i];
      if (bus.pc_in) pcInCount++;
      checks++;
      if (strobes !== es[i]) begin
        failures++;
        $display("FAIL mem_wait cyc%0d: strobes=%h, required %h", i, strobes, es[i]);
      end
    end
    checks++;
    if (pcInCount !== 1) begin
      failures++;
      $display("FAIL mem_wait_pc_in_count: got %0d, required 1", pcInCount);
    end
  endtask

  task automatic test_mul();
    logic [20:0] es [8];
    logic [15:0] er [8];
    logic [4:0]  eo [8];
    es = '{FETCH0, FETCH1, FETCH2, Y_IN | BUSY, Z_IN | BUSY, ZLO_OUT | LO_IN | BUSY,
           ZHI_OUT | HI_IN | DONE | BUSY, 21'd0};
    er = '{16'h0, 16'h0, 16'h0, 16'h0004, 16'h0001, 16'h0, 16'h0, 16'h0};
    eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd16, 5'd0, 5'd0, 5'd0};
    bus.ir = 32'h8100_0000;
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 5) bus.run = 1'b0;
      checks++;
      if (strobes !== es[i] || bus.r_out !== er[i] || bus.r_in !== 16'h0 || bus.alu_op !== eo[i]) begin
        failures++;
        $display("FAIL mul cyc%0d: strobes=%h r_out=%h r_in=%h alu_op=%h, required %h %h 0 %h",
                 i, strobes, bus.r_out, bus.r_in, bus.alu_op, es[i], er[i], eo[i]);
      end
    end
  endtask

  task automatic test_addi();
    logic [20:0] es [6];
    logic [15:0] er [6];
    logic [15:0] ei [6];
    logic [4:0]  eo [6];
    es = '{FETCH0, FETCH1, FETCH2, Y_IN | BUSY, CSIGN_OUT | Z_IN | BUSY, ZLO_OUT | DONE | BUSY};
    er = '{16'h0, 16'h0, 16'h0, 16'h0002, 16'h0, 16'h0};
    ei = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0002};
    eo = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd12, 5'd0};
    bus.ir = 32'h6088_0005;
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (strobes !== es[i] || bus.r_out !== er[i] || bus.r_in !== ei[i] || bus.alu_op !== eo[i]) begin
        failures++;
        $display("FAIL addi cyc%0d: strobes=%h r_out=%h r_in=%h alu_op=%h, required %h %h %h %h",
                 i, strobes, bus.r_out, bus.r_in, bus.alu_op, es[i], er[i], ei[i], eo[i]);
      end
    end
  endtask

  task automatic test_short_ops();
    logic [31:0] irs [3];
    logic [20:0] es  [3];
    logic [15:0] er  [3];
    logic [15:0] ei  [3];
    logic [4:0]  eo  [3];
    // neg R3,R4 (ends T4); mfhi R5 (ends T3); nop (ends T2) -- final step checked, then idle
    irs = '{32'h89A0_0000, 32'hCA80_0000, 32'hD800_0000};
    es  = '{ZLO_OUT | DONE | BUSY, HI_OUT | DONE | BUSY, FETCH2 | DONE};
    er  = '{16'h0, 16'h0, 16'h0};
    ei  = '{16'h0008, 16'h0020, 16'h0};
    eo  = '{5'd0, 5'd0, 5'd0};
    for (int k = 0; k < 3; k++) begin
      bus.ir = irs[k];
      do_reset();
      bus.run = 1'b1;
      tick();
      bus.run = 1'b0;
      for (int i = 0; i < 2 - k + 1; i++) tick();
      if (k == 0) begin
        checks++;
        if (strobes !== (Z_IN | BUSY) || bus.r_out !== 16'h0010 || bus.alu_op !== 5'd17) begin
          failures++;
          $display("FAIL neg_t3: strobes=%h r_out=%h alu_op=%h, required %h 0010 11",
                   strobes, bus.r_out, bus.alu_op, Z_IN | BUSY);
        end
      end
      tick();
      checks++;
      if (strobes !== es[k] || bus.r_out !== er[k] || bus.r_in !== ei[k] || bus.alu_op !== eo[k]) begin
        failures++;
        $display("FAIL short_op%0d_final: strobes=%h r_out=%h r_in=%h alu_op=%h, required %h %h %h %h",
                 k, strobes, bus.r_out, bus.r_in, bus.alu_op, es[k], er[k], ei[k], eo[k]);
      end
      tick();
      checks++;
      if (strobes !== 21'd0) begin
        failures++;
        $display("FAIL short_op%0d_idle: strobes=%h, required 0", k, strobes);
      end
    end
  endtask

  task automatic test_halt();
    bus.ir = 32'hE000_0000;
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (strobes !== BUSY) begin
      failures++;
      $display("FAIL halt_t3: strobes=%h, required %h", strobes, BUSY);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.run = ~bus.run;
      checks++;
      if (strobes !== HALTED) begin
        failures++;
        $display("FAIL halt_sticky cyc%0d: strobes=%h, required %h", i, strobes, HALTED);
      end
    end
    bus.run = 1'b0;
    #2;
    clear = 1'b1;
    #1;
    checks++;
    if (strobes !== 21'd0) begin
      failures++;
      $display("FAIL halt_clear_async: strobes=%h, required 0", strobes);
    end
    tick();
    clear = 1'b0;
  endtask

  task automatic test_illegal();
    bus.ir = 32'hF800_0000;
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (strobes !== BUSY || bus.r_out !== 16'h0 || bus.r_in !== 16'h0 || bus.alu_op !== 5'd0) begin
      failures++;
      $display("FAIL illegal_t3: strobes=%h r_out=%h r_in=%h alu_op=%h, required %h 0 0 0",
               strobes, bus.r_out, bus.r_in, bus.alu_op, BUSY);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (strobes !== ILLEGAL || bus.r_out !== 16'h0 || bus.r_in !== 16'h0) begin
        failures++;
        $display("FAIL illegal_fault cyc%0d: strobes=%h r_out=%h r_in=%h, required %h 0 0",
                 i, strobes, bus.r_out, bus.r_in, ILLEGAL);
      end
    end
  endtask

  task automatic test_clear_mid();
    int rinSeen;
    rinSeen = 0;
    bus.ir = 32'h1891_8000;
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (strobes !== (Z_IN | BUSY) || bus.alu_op !== 5'd3) begin
      failures++;
      $display("FAIL clear_mid_t4: strobes=%h alu_op=%h, required %h 03", strobes, bus.alu_op, Z_IN | BUSY);
    end
    bus.run = 1'b0;
    #2;
    clear = 1'b1;
    #1;
    checks++;
    if (strobes !== 21'd0 || bus.r_out !== 16'h0) begin
      failures++;
      $display("FAIL clear_mid_async: strobes=%h r_out=%h, required 0 0", strobes, bus.r_out);
    end
    tick();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.r_in !== 16'h0) rinSeen++;
      checks++;
      if (strobes !== 21'd0) begin
        failures++;
        $display("FAIL clear_mid_idle cyc%0d: strobes=%h, required 0", i, strobes);
      end
    end
    checks++;
    if (rinSeen !== 0) begin
      failures++;
      $display("FAIL clear_mid_rin: r_in asserted %0d cycles, required 0", rinSeen);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (busViolations !== 0) begin
      failures++;
      $display("FAIL bus_one_source: violations=%0d, required 0", busViolations);
    end
    checks++;
    if (rinViolations !== 0) begin
      failures++;
      $display("FAIL r_in_onehot: violations=%0d, required 0", rinViolations);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    busViolations = 0;
    rinViolations = 0;
    clear         = 1'b1;
    bus.run       = 1'b0;
    bus.mem_ready = 1'b1;
    bus.ir        = 32'h0;
    test_reset();
    test_add();
    test_mem_wait();
    test_mul();
    test_addi();
    test_short_ops();
    test_halt();
    test_illegal();
    test_clear_mid();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound on total simulated time
  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Control-step sequencer for the 25-source shared datapath bus.
- Drives one-hot bus-source enables, register/latch load enables, ALU opcode and the memory read strobe.
- Steps fetch (T0–T2) and execute (T3–T6) for the ALU, immediate, mul/div, move-from-HI/LO, nop and halt instruction classes.
- Guarantees at most one bus source per cycle. The bus resolves overlaps by silent last-wins priority, so the sequencer must never drive two sources at once.

Parameters:
- OPW, 5, opcode field width; ir[31:27].
- REGW, 4, register-index field width; Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- run  in  1  level; high = keep fetching instructions.
- ir  in  32  current IR register contents; valid from T3.
- mem_ready  in  1  memory read data valid this cycle.
- r_out  out  16  one-hot GP register bus source (R0–R15).
- hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, csign_out  out  1 each  bus source enables.
- r_in  out  16  one-hot GP register load.
- pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, read  out  1 each  load/control strobes.
- alu_op  out  5  opcode presented to the ALU.
- busy  out  1  high in any state except IDLE/HALT/FAULT.
- done  out  1  one-cycle pulse on an instruction's final step.
- halted  out  1  high in HALT.
- illegal  out  1  high in FAULT.

Behaviour:
- Reset: clear high asynchronously forces state to IDLE.
- All outputs are Moore-decoded from the registered state and ir; all are 0 in IDLE.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT, FAULT.
- IDLE→T0 when run=1.
- Fetch steps:
  - T0: pc_out, mar_in, inc_pc, z_in.
  - T1: zlo_out, pc_in (first T1 cycle only), read, mdr_in. Hold T1 with read and mdr_in high until mem_ready=1. pc_in is asserted exactly once per fetch.
  - T2: mdr_out, ir_in.
- Execute by opcode (ir[31:27]); unlisted opcodes in T3 go to FAULT.
  - 00011–01011 (reg-reg ALU):
    - T3: r_out[Rb], y_in.
    - T4: r_out[Rc], alu_op=opcode, z_in.
    - T5: zlo_out, r_in[Ra], done.
  - 01100–01110 (immediate): as reg-reg, except T4 uses csign_out instead of r_out[Rc].
  - 10001/10010 (neg/not):
    - T3: r_out[Rb], alu_op, z_in.
    - T4: zlo_out, r_in[Ra], done.
  - 01111/10000 (div/mul):
    - T3: r_out[Ra], y_in.
    - T4: r_out[Rb], alu_op, z_in.
    - T5: zlo_out, lo_in.
    - T6: zhi_out, hi_in, done.
  - 11001/11010 (mfhi/mflo): T3: hi_out or lo_out, r_in[Ra], done.
  - 11011 (nop): T2 asserts done and completes.
  - 11100 (halt): T3 goes to HALT, done=0.
- After the done step: next state is T0 if run=1, else IDLE. run is sampled only there, so an instruction in progress always completes.
- HALT and FAULT are sticky; only clear exits them.
- alu_op=0 in every state except the z_in execute step.
- Invariant: popcount of all bus-source enables (r_out plus the 7 single-bit sources) ≤ 1 every cycle.
- Invariant: r_in is one-hot or zero.
- Ra=Rb=Rc is legal; indices come straight from ir with no special handling of R0.
- clear mid-instruction: return to IDLE immediately; the partial instruction is abandoned with no further strobes.

Test Plan:
- Reset then run=1, mem_ready=1, ir=0x18918000 (add R1,R2,R3): T0..T5 take 6 cycles. T3 r_out=0x0004 + y_in; T4 r_out=0x0008 + alu_op=00011; T5 zlo_out + r_in=0x0002 + done. Next state is T0.
- mem_ready held low 3 cycles in T1: read and mdr_in stay high 4 cycles and pc_in pulses once. IRin happens the cycle after mem_ready rises.
- ir=0x81000000 (mul R2,R0): T5 lo_in + zlo_out, T6 hi_in + zhi_out + done; 7 cycles total.
- ir=0x60880005 (addi R1,R1,5): T4 csign_out=1 with r_out=0, alu_op=01100.
- ir=0xE0000000 (halt): busy drops, halted=1 from the cycle after T3 and stays high with run toggling. clear returns to IDLE.
- Opcode 11111 → illegal=1 and all enables 0. Separately, assert clear in T4 of an add: IDLE next edge, r_in never asserted.
- Every test: a checker flags any cycle where more than one bus source is active.
